// File: rtl/m_extension_pkg.sv
// Shared M-extension types: funct3 encodings, multiply-controller FSM states,
// default multiplier latency and the operand/result selection helpers.
package m_extension;

   typedef enum logic [2:0] {
      F3_MUL    = 3'b000,
      F3_MULH   = 3'b001,
      F3_MULHSU = 3'b010,
      F3_MULHU  = 3'b011
   } m_funct3;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } mul_ctrl_state_t;

   localparam int MUL_LAT_DEFAULT = 5;

   // rs1 is sign-extended for mulh/mulhsu, rs2 only for mulh; the 64-bit product
   // is exact for every variant after truncation.
   function automatic logic [31:0] mul_select(input logic [31:0] a,
                                              input logic [31:0] b,
                                              input m_funct3     f);
      logic signed [32:0] sa;
      logic signed [32:0] sb;
      logic signed [63:0] p;
      logic [31:0]        r;
      sa = signed'({((f == F3_MULH) || (f == F3_MULHSU)) ? a[31] : 1'b0, a});
      sb = signed'({(f == F3_MULH) ? b[31] : 1'b0, b});
      p  = sa * sb;
      case (f)
         F3_MUL:  r = p[31:0];
         default: r = p[63:32];
      endcase
      return r;
   endfunction

   function automatic logic op_match(input logic [31:0] rs1_a,
                                     input logic [31:0] rs2_a,
                                     input m_funct3     f_a,
                                     input logic [31:0] rs1_b,
                                     input logic [31:0] rs2_b,
                                     input m_funct3     f_b);
      return (rs1_a == rs1_b) && (rs2_a == rs2_b) && (f_a == f_b);
   endfunction

endpackage

// File: rtl/mul_issue_ctrl_multiplier.sv
// Fixed-latency multiplier: raises mul_done on the MUL_LAT-th consecutive
// is_mul-high cycle; dropping is_mul restarts the count.
module multiplier
   import m_extension::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        is_mul,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  m_funct3     funct3,
   output logic        mul_done,
   output logic [31:0] mul_out
);

   localparam logic [7:0] LAST_CNT = 8'(MUL_LAT - 1);

   logic [7:0]  cnt_r;
   logic [31:0] mul_out_r;

   // Latency counter and product register; operands are stable for the whole
   // is_mul window, so the product is valid from the second cycle onward.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r     <= 8'd0;
         mul_out_r <= 32'd0;
      end else if (!is_mul) begin
         cnt_r     <= 8'd0;
         mul_out_r <= mul_out_r;
      end else begin
         cnt_r     <= (cnt_r == LAST_CNT) ? cnt_r : cnt_r + 8'd1;
         mul_out_r <= mul_select(rs1_data, rs2_data, funct3);
      end
   end

   assign mul_done = is_mul && (cnt_r == LAST_CNT);
   assign mul_out  = mul_out_r;

endmodule

// File: rtl/mul_issue_ctrl.sv
// Multiply issue controller: accepts ops from EX, bypasses repeats of the last
// completed op, otherwise drives the multiplier and returns its result.
module mul_issue_ctrl
   import m_extension::*;
#(
   parameter int MUL_LAT = MUL_LAT_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_rs1,
   input  logic [31:0] req_rs2,
   input  m_funct3     req_funct3,
   input  logic        flush,
   output logic        resp_valid,
   output logic [31:0] resp_data,
   input  logic        resp_ready,
   output logic [15:0] hit_count
);

   localparam logic [7:0] LAST_CNT = 8'(MUL_LAT - 1);

   mul_ctrl_state_t state_r;
   mul_ctrl_state_t next_state_s;

   logic [31:0] op_rs1_r;
   logic [31:0] op_rs2_r;
   m_funct3     op_funct3_r;
   logic [31:0] result_r;
   logic [7:0]  busy_cnt_r;
   logic [31:0] last_rs1_r;
   logic [31:0] last_rs2_r;
   m_funct3     last_funct3_r;
   logic [31:0] last_result_r;
   logic        last_valid_r;
   logic [15:0] hit_count_r;
   logic        proto_err;

   logic        req_ready_s;
   logic        accept_s;
   logic        hit_s;
   logic        complete_s;
   logic        is_mul;
   logic        mul_done;
   logic [31:0] mul_out;

   multiplier #(.MUL_LAT(MUL_LAT)) u_multiplier (
      .clk      (clk),
      .rst      (rst),
      .is_mul   (is_mul),
      .rs1_data (op_rs1_r),
      .rs2_data (op_rs2_r),
      .funct3   (op_funct3_r),
      .mul_done (mul_done),
      .mul_out  (mul_out)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Handshake decode and next state; flush overrides every other input.
   always_comb begin
      req_ready_s  = ~flush & ((state_r == IDLE) | ((state_r == RESP) & resp_ready));
      accept_s     = req_valid & req_ready_s;
      hit_s        = accept_s & last_valid_r &
                     op_match(req_rs1, req_rs2, req_funct3,
                              last_rs1_r, last_rs2_r, last_funct3_r);
      complete_s   = ~flush & (state_r == BUSY) & mul_done;
      next_state_s = state_r;
      if (flush) begin
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  next_state_s = hit_s ? RESP : BUSY;
               end else begin
                  next_state_s = IDLE;
               end
            end
            BUSY: begin
               if (mul_done) begin
                  next_state_s = RESP;
               end else begin
                  next_state_s = BUSY;
               end
            end
            RESP: begin
               if (accept_s) begin
                  next_state_s = hit_s ? RESP : BUSY;
               end else if (resp_ready) begin
                  next_state_s = IDLE;
               end else begin
                  next_state_s = RESP;
               end
            end
            default: next_state_s = IDLE;
         endcase
      end
   end

   // Operand capture, result/bypass bookkeeping, hit counter and protocol flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_rs1_r      <= 32'd0;
         op_rs2_r      <= 32'd0;
         op_funct3_r   <= F3_MUL;
         result_r      <= 32'd0;
         busy_cnt_r    <= 8'd0;
         last_rs1_r    <= 32'd0;
         last_rs2_r    <= 32'd0;
         last_funct3_r <= F3_MUL;
         last_result_r <= 32'd0;
         last_valid_r  <= 1'b0;
         hit_count_r   <= 16'd0;
         proto_err     <= 1'b0;
      end else begin
         if (accept_s) begin
            op_rs1_r    <= req_rs1;
            op_rs2_r    <= req_rs2;
            op_funct3_r <= req_funct3;
            busy_cnt_r  <= 8'd0;
         end else if ((state_r == BUSY) && (busy_cnt_r != 8'hFF)) begin
            busy_cnt_r  <= busy_cnt_r + 8'd1;
         end
         if (hit_s) begin
            result_r <= last_result_r;
            if (hit_count_r != 16'hFFFF) begin
               hit_count_r <= hit_count_r + 16'd1;
            end
         end else if (complete_s) begin
            result_r      <= mul_out;
            last_rs1_r    <= op_rs1_r;
            last_rs2_r    <= op_rs2_r;
            last_funct3_r <= op_funct3_r;
            last_result_r <= mul_out;
            last_valid_r  <= 1'b1;
         end
         if (~flush && (state_r == BUSY) && (busy_cnt_r == LAST_CNT) && !mul_done) begin
            proto_err <= 1'b1;
         end
      end
   end

   assign is_mul     = (state_r == BUSY);
   assign req_ready  = req_ready_s;
   assign resp_valid = (state_r == RESP);
   assign resp_data  = result_r;
   assign hit_count  = hit_count_r;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl: latency, bypass, back-to-back, flush,
// stall and reset scenarios with hand-computed results.
module tb_mul_issue_ctrl;
   import m_extension::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_rs1;
   logic [31:0] req_rs2;
   m_funct3     req_funct3;
   logic        flush;
   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_ready;
   logic [15:0] hit_count;

   int checks = 0;
   int errors = 0;

   mul_issue_ctrl #(.MUL_LAT(5)) dut (
      .clk        (clk),
      .rst        (rst),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_rs1    (req_rs1),
      .req_rs2    (req_rs2),
      .req_funct3 (req_funct3),
      .flush      (flush),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .resp_ready (resp_ready),
      .hit_count  (hit_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one op for a single edge; returns in cycle 1 after acceptance.
   task automatic issue(input m_funct3 f, input logic [31:0] a, input logic [31:0] b);
      req_valid  = 1'b1;
      req_funct3 = f;
      req_rs1    = a;
      req_rs2    = b;
      tick();
      req_valid  = 1'b0;
   endtask

   // Counts cycles after acceptance until resp_valid; 0 means it never came.
   task automatic wait_resp(output int cyc);
      cyc = 1;
      while (!resp_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      if (!resp_valid) cyc = 0;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b0; req_rs1 = 32'd0; req_rs2 = 32'd0;
      req_funct3 = F3_MUL; flush = 1'b0; resp_ready = 1'b1;
      tick(); tick();
      rst = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
      checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL reset_resp_data: got %h want 0", resp_data); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready: got %b want 1", req_ready); end
      checks++; if (dut.is_mul !== 1'b0) begin errors++; $display("FAIL reset_is_mul: got %b want 0", dut.is_mul); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL reset_hit_count: got %0d want 0", hit_count); end
   endtask

   task automatic test_mul_basic();
      int c;
      issue(F3_MUL, 32'd7, 32'd6);
      checks++; if (dut.is_mul !== 1'b1) begin errors++; $display("FAIL basic_is_mul: got %b want 1", dut.is_mul); end
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL basic_latency: got %0d want 6", c); end
      checks++; if (resp_data !== 32'h0000002A) begin errors++; $display("FAIL basic_data: got %h want 0000002a", resp_data); end
      tick();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL basic_consumed: got %b want 0", resp_valid); end
   endtask

   task automatic test_bypass();
      int c;
      issue(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL bypass_miss_latency: got %0d want 6", c); end
      checks++; if (resp_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL bypass_miss_data: got %h want fffffffe", resp_data); end
      tick();
      issue(F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_resp(c);
      checks++; if (c !== 1) begin errors++; $display("FAIL bypass_hit_latency: got %0d want 1", c); end
      checks++; if (resp_data !== 32'hFFFFFFFE) begin errors++; $display("FAIL bypass_hit_data: got %h want fffffffe", resp_data); end
      checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL bypass_hit_count: got %0d want 1", hit_count); end
      tick();
   endtask

   task automatic test_back_to_back();
      int c;
      issue(F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF);
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL b2b_first_latency: got %0d want 6", c); end
      checks++; if (resp_data !== 32'h00000000) begin errors++; $display("FAIL b2b_first_data: got %h want 00000000", resp_data); end
      req_valid = 1'b1; req_funct3 = F3_MULHSU; req_rs1 = 32'hFFFFFFFF; req_rs2 = 32'h00000002;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_in_resp: got %b want 1", req_ready); end
      tick();
      req_valid = 1'b0;
      checks++; if (dut.is_mul !== 1'b1) begin errors++; $display("FAIL b2b_no_idle_bubble: is_mul got %b want 1", dut.is_mul); end
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL b2b_second_latency: got %0d want 6", c); end
      checks++; if (resp_data !== 32'hFFFFFFFF) begin errors++; $display("FAIL b2b_second_data: got %h want ffffffff", resp_data); end
      tick();
   endtask

   task automatic test_flush();
      int c;
      int seen;
      issue(F3_MUL, 32'd3, 32'd5);
      tick(); tick();
      flush = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL flush_blocks_ready: got %b want 0", req_ready); end
      tick();
      checks++; if (dut.is_mul !== 1'b0) begin errors++; $display("FAIL flush_is_mul: got %b want 0", dut.is_mul); end
      flush = 1'b0;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL flush_ready_after: got %b want 1", req_ready); end
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         if (resp_valid) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL flush_no_resp: got %0d resp cycles want 0", seen); end
      issue(F3_MUL, 32'd3, 32'd5);
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL flush_retry_latency: got %0d want 6", c); end
      checks++; if (resp_data !== 32'h0000000F) begin errors++; $display("FAIL flush_retry_data: got %h want 0000000f", resp_data); end
      checks++; if (hit_count !== 16'd1) begin errors++; $display("FAIL flush_hit_count: got %0d want 1", hit_count); end
      tick();
      resp_ready = 1'b0;
      issue(F3_MUL, 32'd2, 32'd2);
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL flush_resp_latency: got %0d want 6", c); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL flush_in_resp: got %b want 0", resp_valid); end
      resp_ready = 1'b1;
   endtask

   task automatic test_stall();
      int c;
      resp_ready = 1'b0;
      issue(F3_MUL, 32'h00001234, 32'h00000010);
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL stall_latency: got %0d want 6", c); end
      for (int i = 0; i < 3; i++) begin
         checks++; if (resp_valid !== 1'b1) begin errors++; $display("FAIL stall_valid_%0d: got %b want 1", i, resp_valid); end
         checks++; if (resp_data !== 32'h00012340) begin errors++; $display("FAIL stall_data_%0d: got %h want 00012340", i, resp_data); end
         checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL stall_ready_%0d: got %b want 0", i, req_ready); end
         if (i < 2) tick();
      end
      resp_ready = 1'b1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_consume_ready: got %b want 1", req_ready); end
      tick();
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL stall_consumed: got %b want 0", resp_valid); end
   endtask

   task automatic test_reset_mid_busy();
      int c;
      int seen;
      issue(F3_MUL, 32'd9, 32'd9);
      wait_resp(c);
      checks++; if (resp_data !== 32'h00000051) begin errors++; $display("FAIL rstmid_prime_data: got %h want 00000051", resp_data); end
      tick();
      issue(F3_MUL, 32'd8, 32'd8);
      tick(); tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resp_valid: got %b want 0", resp_valid); end
      checks++; if (resp_data !== 32'd0) begin errors++; $display("FAIL rstmid_resp_data: got %h want 0", resp_data); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready: got %b want 1", req_ready); end
      checks++; if (dut.is_mul !== 1'b0) begin errors++; $display("FAIL rstmid_is_mul: got %b want 0", dut.is_mul); end
      checks++; if (hit_count !== 16'd0) begin errors++; $display("FAIL rstmid_hit_count: got %0d want 0", hit_count); end
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (resp_valid) seen++;
         tick();
      end
      checks++; if (seen !== 0) begin errors++; $display("FAIL rstmid_no_resp: got %0d resp cycles want 0", seen); end
      issue(F3_MUL, 32'd9, 32'd9);
      wait_resp(c);
      checks++; if (c !== 6) begin errors++; $display("FAIL rstmid_miss_latency: got %0d want 6", c); end
      checks++; if (resp_data !== 32'h00000051) begin errors++; $display("FAIL rstmid_miss_data: got %h want 00000051", resp_data); end
      tick();
   endtask

   task automatic test_protocol();
      checks++; if (dut.proto_err !== 1'b0) begin errors++; $display("FAIL protocol_err: got %b want 0", dut.proto_err); end
   endtask

   initial begin
      test_reset();
      test_mul_basic();
      test_bypass();
      test_back_to_back();
      test_flush();
      test_stall();
      test_protocol();
      test_reset_mid_busy();
      test_protocol();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/mul_issue_ctrl.md
MUL_ISSUE_CTRL -- requirements
Module: mul_issue_ctrl

Interface
REQ-001 Parameter: MUL_LAT, default 5, number of is_mul-high cycles up to and including the multiplier's mul_done cycle.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: rst  in  1  synchronous, active-high reset.
REQ-004 Port: req_valid  in  1  upstream EX stage presents a multiply op.
REQ-005 Port: req_ready  out  1  controller accepts the op this cycle.
REQ-006 Port: req_rs1, req_rs2  in  32 each  operands; rs1 signed and rs2 unsigned for mulhsu.
REQ-007 Port: req_funct3  in  m_funct3  op select; upstream SHALL drive only mul/mulh/mulhsu/mulhu.
REQ-008 Port: flush  in  1  kill any in-flight or pending op.
REQ-009 Port: resp_valid  out  1  result available.
REQ-010 Port: resp_data  out  32  result.
REQ-011 Port: resp_ready  in  1  downstream consumes result.
REQ-012 Port: hit_count  out  16  count of bypass hits, saturating.

Function
REQ-013 The FSM SHALL use states IDLE, BUSY and RESP.
REQ-014 req_ready SHALL equal ~flush & (IDLE | (RESP & resp_ready)).
REQ-015 Acceptance (req_valid & req_ready) SHALL register rs1, rs2 and funct3 into op registers that stay stable until the next acceptance.
REQ-016 On acceptance with last_valid set and rs1, rs2 and funct3 all equal to the last completed op, the FSM SHALL go to RESP with resp_data = last_result, and hit_count SHALL increment, saturating at 0xFFFF.
REQ-017 On acceptance without a match, the FSM SHALL go to BUSY, and the busy counter SHALL clear to 0.
REQ-018 is_mul to the multiplier SHALL be high exactly while in BUSY; op registers SHALL drive rs1_data, rs2_data and funct3.
REQ-019 In BUSY, the busy counter SHALL increment each cycle.
REQ-020 When mul_done is high in BUSY, the controller SHALL capture mul_out into the result register, update last_rs1, last_rs2, last_funct3 and last_result, set last_valid, and go to RESP.
REQ-021 Latency: the miss path SHALL give resp_valid high in the (MUL_LAT+1)th cycle after the acceptance edge; the hit path SHALL give resp_valid high in the 1st cycle after it.
REQ-022 Protocol check: if the busy counter reaches MUL_LAT-1 without mul_done, the controller SHALL assert an error flag and the bench SHALL flag it.
REQ-023 resp_valid SHALL be high exactly in RESP.
REQ-024 resp_data SHALL be held stable while resp_valid & ~resp_ready.
REQ-025 In RESP with resp_ready and no new acceptance, the FSM SHALL go to IDLE.
REQ-026 In RESP with resp_ready and a simultaneous acceptance, the FSM SHALL apply REQ-016/017 directly, with no IDLE bubble.
REQ-027 Flush in BUSY SHALL force IDLE the next cycle and drop is_mul, which resets the multiplier counter; last_* SHALL be unchanged.
REQ-028 Flush in RESP SHALL drop the response and force IDLE.
REQ-029 Flush takes priority over req_valid, mul_done and resp_ready in the same cycle.
REQ-030 A flushed op SHALL never produce resp_valid.
REQ-031 After a flush, a new op SHALL be acceptable the cycle after flush deasserts.

Reset
REQ-032 rst SHALL set state IDLE, clear last_valid, clear op registers, result and busy counter to 0, and clear hit_count to 0.
REQ-033 Out of reset: resp_valid=0, resp_data=0, req_ready=1 when flush=0, is_mul=0.
REQ-034 rst mid-BUSY or mid-RESP SHALL discard the op, and no response SHALL follow.

Structure
REQ-035 mul_ctrl_state_t (IDLE/BUSY/RESP) and the MUL_LAT default SHALL be added to package m_extension; m_funct3 SHALL be reused from that package.
REQ-036 The module SHALL instantiate exactly one sub-module, multiplier, sharing clk and rst.

Verification
REQ-037 mul, 7 x 6, resp_ready=1 -> resp_data=0x0000002A, resp_valid in the 6th cycle after acceptance.
REQ-038 mulhu 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; repeat same op -> same data 1 cycle after acceptance, hit_count=1.
REQ-039 mulh 0xFFFFFFFF x 0xFFFFFFFF, then mulhsu 0xFFFFFFFF x 0x00000002 back-to-back with resp_ready=1 -> 0x00000000 then 0xFFFFFFFF, no IDLE cycle between.
REQ-040 mul 3 x 5, flush in 3rd BUSY cycle -> no resp_valid, is_mul low next cycle; then mul 3 x 5 -> miss, 0x0000000F after full latency.
REQ-041 resp_ready low for 3 cycles in RESP -> resp_valid and resp_data held unchanged, req_ready=0 until the consume cycle.
REQ-042 rst asserted mid-BUSY -> all outputs at reset values next cycle; a following identical op misses the bypass and takes full latency.
